// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, drives a 1-cycle synchronous code RAM
// and buffers returned words in a small prefetch FIFO handed downstream over valid/ready.
module ifetch_queue #(
  parameter int          ADDR_W   = 9,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     imem_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              kill;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       credit;

  assign inst_valid = resetn && (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = resetn && vld_p1 && !kill && !redirect_valid;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    // Words already buffered plus the one still in the RAM must leave room for this request.
    credit    = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
    case (state)
      IDLE: state_nxt = RUN;
      RUN:  issue = resetn && !redirect_valid && (credit < (CW+1)'(DEPTH));
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      fetch_pc <= ADDR_W'(RESET_PC);
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      vld_p1   <= 1'b0;
      kill     <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      // With a 1-cycle RAM the response always lands inside the redirect cycle, so this stays 0.
      kill   <= redirect_valid && issue;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 1'b1;
        if (push)  tail     <= tail + 1'b1;
        if (pop)   head     <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // p1: address of the word returning from the RAM this cycle
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
    if (push) begin
      data_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= pc_p1;
    end
  end

  assign imem_en    = issue;
  assign imem_addr  = fetch_pc;
  assign inst_data  = inst_valid ? data_mem[head] : '0;
  assign inst_pc    = inst_valid ? pc_mem[head]   : '0;
  assign fifo_count = resetn ? count : '0;

  assert property (@(posedge clk) disable iff (!resetn)
                   !(push && (count == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ifetch_queue;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .resetn(resetn),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Code memory: mem[i] = i + 0x100, one cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h100 + 32'(imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words waiting for the consumer, and the one request in the RAM
  bit m_run = 1'b0;
  int m_fetch = 0;
  int m_q[$];
  bit m_infl = 1'b0;
  int m_infl_pc = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin : model_upd
    int sz;
    bit p;
    bit iss;
    bit psh;
    if (!resetn) begin
      m_run = 1'b0; m_fetch = 0; m_q.delete(); m_infl = 1'b0; model_ok = 1'b1;
    end else begin
      sz  = m_q.size();
      p   = (sz > 0) && inst_ready;
      iss = m_run && !redirect_valid && (sz + int'(m_infl) - int'(p) < DEPTH);
      psh = m_infl && !redirect_valid;
      if (redirect_valid) m_q.delete();
      else begin
        if (p) void'(m_q.pop_front());
        if (psh) m_q.push_back(m_infl_pc);
      end
      m_infl = iss;
      if (iss) m_infl_pc = m_fetch;
      if (redirect_valid) m_fetch = int'(redirect_pc);
      else if (iss) m_fetch = (m_fetch + 1) % (1 << ADDR_W);
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    int sz;
    bit ev;
    bit ep;
    bit een;
    if (model_ok) begin
      sz  = resetn ? m_q.size() : 0;
      ev  = sz > 0;
      ep  = ev && inst_ready;
      een = resetn && m_run && !redirect_valid && (sz + int'(m_infl) - int'(ep) < DEPTH);
      chk("m_imem_en", 32'(imem_en), 32'(een));
      if (een) chk("m_imem_addr", 32'(imem_addr), m_fetch);
      chk("m_inst_valid", 32'(inst_valid), 32'(ev));
      chk("m_inst_pc", 32'(inst_pc), ev ? m_q[0] : 0);
      chk("m_inst_data", inst_data, ev ? 32'h100 + m_q[0] : 0);
      chk("m_fifo_count", 32'(fifo_count), sz);
    end
  end

  task automatic tick(input bit rn, input bit rdy, input bit rv, input logic [ADDR_W-1:0] rpc);
    @(posedge clk);
    #2;
    resetn = rn; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
  endtask

  initial begin : stim
    int n_en;
    // 1: reset release, streaming
    repeat (3) tick(0, 1, 0, 0);
    chk("t1_reset_count", 32'(fifo_count), 0);
    chk("t1_reset_valid", 32'(inst_valid), 0);
    tick(1, 1, 0, 0);
    chk("t1_idle_en", 32'(imem_en), 0);
    tick(1, 1, 0, 0);
    chk("t1_first_en", 32'(imem_en), 1);
    chk("t1_first_addr", 32'(imem_addr), 0);
    tick(1, 1, 0, 0);
    chk("t1_c2_valid", 32'(inst_valid), 0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0, 0);
      chk("t1_valid", 32'(inst_valid), 1);
      chk("t1_pc", 32'(inst_pc), k);
      chk("t1_data", inst_data, 32'h100 + k);
    end

    // 2: consumer stalled from start, then released
    repeat (2) tick(0, 0, 0, 0);
    n_en = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 0, 0);
      n_en += int'(imem_en);
    end
    chk("t2_en_pulses", n_en, 4);
    chk("t2_full_count", 32'(fifo_count), 4);
    chk("t2_head_pc", 32'(inst_pc), 0);
    for (int k = 0; k < 8; k++) begin
      tick(1, 1, 0, 0);
      chk("t2_valid", 32'(inst_valid), 1);
      chk("t2_pc", 32'(inst_pc), k);
    end

    // 3: redirect with 3 buffered words and one read in flight
    repeat (2) tick(0, 0, 0, 0);
    repeat (5) tick(1, 0, 0, 0);
    tick(1, 0, 1, 9'h040);
    chk("t3_pre_count", 32'(fifo_count), 3);
    chk("t3_redir_en", 32'(imem_en), 0);
    tick(1, 1, 0, 0);
    chk("t3_flush_count", 32'(fifo_count), 0);
    chk("t3_flush_valid", 32'(inst_valid), 0);
    chk("t3_new_en", 32'(imem_en), 1);
    chk("t3_new_addr", 32'(imem_addr), 32'h40);
    tick(1, 1, 0, 0);
    chk("t3_t2_valid", 32'(inst_valid), 0);
    tick(1, 1, 0, 0);
    chk("t3_t3_pc", 32'(inst_pc), 32'h40);
    chk("t3_t3_data", inst_data, 32'h140);
    tick(1, 1, 0, 0);
    chk("t3_t4_pc", 32'(inst_pc), 32'h41);

    // 4: redirect in the same cycle as a pop
    tick(1, 1, 1, 9'h010);
    chk("t4_pop_valid", 32'(inst_valid), 1);
    chk("t4_pop_pc", 32'(inst_pc), 32'h42);
    tick(1, 1, 0, 0);
    chk("t4_t1_valid", 32'(inst_valid), 0);
    tick(1, 1, 0, 0);
    chk("t4_t2_valid", 32'(inst_valid), 0);
    tick(1, 1, 0, 0);
    chk("t4_t3_pc", 32'(inst_pc), 32'h10);

    // 5: PC wrap
    tick(1, 1, 1, 9'h1FF);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("t5_pc_1ff", 32'(inst_pc), 32'h1FF);
    chk("t5_data_1ff", inst_data, 32'h2FF);
    tick(1, 1, 0, 0);
    chk("t5_pc_000", 32'(inst_pc), 0);
    chk("t5_data_000", inst_data, 32'h100);
    tick(1, 1, 0, 0);
    chk("t5_pc_001", 32'(inst_pc), 1);

    // 6: random ready and redirects, one mid-stream reset
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000 || i == 1001)
        tick(0, 1'($urandom_range(0, 1)), 0, 0);
      else
        tick(1, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
             ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
